// File: rtl/ff_exerciser_pkg.sv
// rtl/ff_exerciser_pkg.sv - shared state encoding, vector tables and reference model for ff_exerciser
//
// Contents:
//   ST_*          FSM state encoding
//   NUM_VECTORS   number of auto self-test vectors
//   VEC_TABLE     auto-test stimulus, each entry {d,j,k,t}
//   EXP_TABLE     bank outputs {t_q,jk_q,d_q} after each vector, starting from 000
//   model_next()  next state of the reference D/JK/T flops for one capture
package ff_exerciser_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_APPLY  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int NUM_VECTORS = 8;

    localparam logic [3:0] VEC_TABLE [NUM_VECTORS] = '{
        4'b1101, 4'b0011, 4'b1110, 4'b1111,
        4'b0001, 4'b0100, 4'b1011, 4'b0110
    };

    localparam logic [2:0] EXP_TABLE [NUM_VECTORS] = '{
        3'b111, 3'b000, 3'b011, 3'b101,
        3'b000, 3'b010, 3'b101, 3'b110
    };

    // q is ordered like the bank outputs: [0] D flop, [1] JK flop, [2] T flop.
    function automatic logic [2:0] model_next(input logic [2:0] q,
                                              input logic       d,
                                              input logic       j,
                                              input logic       k,
                                              input logic       t);
        logic jk_q;
        case ({j, k})
            2'b01:   jk_q = 1'b0;
            2'b10:   jk_q = 1'b1;
            2'b11:   jk_q = ~q[1];
            default: jk_q = q[1];
        endcase
        return {q[2] ^ t, jk_q, d};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button synchronizer, debouncer and rising-edge step pulse
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   btn    in   raw asynchronous button level
//   step   out  one-cycle pulse when the debounced level rises
module btn_debounce
#(
    parameter int DEBOUNCE_CYCLES = 16
)
(
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic step
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles in which the synchronized input disagrees
    // with the accepted level; any agreeing cycle restarts the count, so a
    // glitch shorter than DEBOUNCE_CYCLES never reaches CNT_LAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            step  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            step  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                step  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ff_exerciser.sv
// rtl/ff_exerciser.sv - manual single-step / auto self-test exerciser for a D/JK/T flop bank
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset (shared with the flop bank)
//   step_btn   in   raw push-button, one press = one step or one run
//   mode       in   0 manual single-step, 1 auto self-test (sampled in IDLE)
//   sw_in[3:0] in   manual stimulus {t,k,j,d}
//   ff_q[2:0]  in   bank outputs [0] D, [1] JK, [2] T
//   ff_en      out  one-cycle capture enable to the bank
//   d,j,k,t    out  registered bank data inputs
//   busy       out  high outside IDLE and DONE
//   pass,fail  out  sticky auto-test result
//   vec_idx    out  current vector, holds the failing index on fail
module ff_exerciser
    import ff_exerciser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step_btn,
    input  logic       mode,
    input  logic [3:0] sw_in,
    input  logic [2:0] ff_q,
    output logic       ff_en,
    output logic       d,
    output logic       j,
    output logic       k,
    output logic       t,
    output logic       busy,
    output logic       pass,
    output logic       fail,
    output logic [2:0] vec_idx
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_VECTORS - 1);

    logic       step;
    logic [2:0] state;
    logic       auto_run;
    logic [2:0] model_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .reset (reset),
        .btn   (step_btn),
        .step  (step)
    );

    assign busy = (state != ST_IDLE) && (state != ST_DONE);

    // Steps are only looked at in IDLE and DONE, so presses while busy are
    // dropped. mode is captured into auto_run on leaving IDLE, so later mode
    // changes cannot redirect a run in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            auto_run <= 1'b0;
            model_q  <= 3'b000;
            ff_en    <= 1'b0;
            d        <= 1'b0;
            j        <= 1'b0;
            k        <= 1'b0;
            t        <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            vec_idx  <= 3'd0;
        end else begin
            ff_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (step) begin
                        auto_run <= mode;
                        if (mode) begin
                            pass    <= 1'b0;
                            fail    <= 1'b0;
                            vec_idx <= 3'd0;
                        end else begin
                            {t, k, j, d} <= sw_in;
                        end
                        state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (auto_run) begin
                        {d, j, k, t} <= VEC_TABLE[vec_idx];
                    end
                    // Registered so that ff_en is high exactly during STROBE.
                    ff_en <= 1'b1;
                    state <= ST_STROBE;
                end
                ST_STROBE: begin
                    // Model advances on the same edge at which the bank captures.
                    model_q <= model_next(model_q, d, j, k, t);
                    state   <= auto_run ? ST_CHECK : ST_IDLE;
                end
                ST_CHECK: begin
                    if (ff_q != model_q) begin
                        fail  <= 1'b1;
                        state <= ST_DONE;
                    end else if (vec_idx == LAST_IDX) begin
                        pass  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        vec_idx <= vec_idx + 3'd1;
                        state   <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    if (step) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
